// File: rtl/atmega_pll_ctrl_pkg.sv
// Shared encodings for the ATmega PLL sequencing controller: FSM states,
// PLLCSR bit positions and the counter width helper.
package atmega_pll_ctrl_pkg;

    localparam logic [1:0] ST_OFF    = 2'd0;
    localparam logic [1:0] ST_LOCK   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [1:0] ST_RETUNE = 2'd3;

    localparam logic [1:0] SW_IDLE   = 2'd0;
    localparam logic [1:0] SW_GUARD  = 2'd1;
    localparam logic [1:0] SW_SETTLE = 2'd2;

    localparam int PLOCK_BIT  = 0;
    localparam int PLLE_BIT   = 1;
    localparam int PINDIV_BIT = 4;

    // Wide enough for the larger of the two down-counters, never wraps.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/atmega_pll_clk_switch.sv
// Glitch-free timer clock source switch: gates the timer clock, waits a guard
// interval, changes the source, then re-enables the clock.
module atmega_pll_clk_switch
    import atmega_pll_ctrl_pkg::*;
#(
    parameter int SWITCH_GUARD = 4,
    parameter int CNT_W        = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_plock,
    input  logic [1:0] i_frq_sel,
    output logic [1:0] o_tim_sel,
    output logic       o_tim_gate,
    output logic       o_sw_idle
);

    localparam logic [CNT_W-1:0] GUARD_RELOAD = CNT_W'(SWITCH_GUARD - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_sel;
    logic             r_gate;
    logic [1:0]       w_target;

    // An unlocked PLL must never clock the timer, so fall back to source 00.
    assign w_target = i_plock ? i_frq_sel : 2'b00;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= SW_IDLE;
            r_cnt   <= '0;
            r_sel   <= 2'b00;
            r_gate  <= 1'b1;
        end else begin
            case (r_state)
                SW_IDLE: begin
                    if (w_target != r_sel) begin
                        r_state <= SW_GUARD;
                        r_gate  <= 1'b0;
                        r_cnt   <= GUARD_RELOAD;
                    end
                end
                SW_GUARD: begin
                    // Target sampled only here, so late changes during the guard win.
                    if (r_cnt == '0) begin
                        r_sel   <= w_target;
                        r_state <= SW_SETTLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                SW_SETTLE: begin
                    r_gate  <= 1'b1;
                    r_state <= SW_IDLE;
                end
                default: begin
                    r_gate  <= 1'b1;
                    r_state <= SW_IDLE;
                end
            endcase
        end
    end

    assign o_tim_sel  = r_sel;
    assign o_tim_gate = r_gate;
    assign o_sw_idle  = (r_state == SW_IDLE);

endmodule

// File: rtl/atmega_pll_ctrl.sv
// PLLCSR/PLLFRQ register owner and PLL enable/lock/retune sequencer; drives
// the PLL divider configuration and the timer clock switch.
module atmega_pll_ctrl
    import atmega_pll_ctrl_pkg::*;
#(
    parameter int BUS_ADDR_DATA_LEN = 16,
    parameter int PLLCSR_ADDR       = 'h49,
    parameter int PLLFRQ_ADDR       = 'h52,
    parameter int LOCK_CYCLES       = 1024,
    parameter int SWITCH_GUARD      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr_dat,
    input  logic                         wr_dat,
    input  logic                         rd_dat,
    input  logic [7:0]                   bus_dat_in,
    output logic [7:0]                   bus_dat_out,
    output logic                         pll_run,
    output logic [7:0]                   pll_frq,
    output logic [1:0]                   tim_sel,
    output logic                         tim_gate,
    output logic                         plock
);

    localparam int                           CNT_W       = cnt_width(LOCK_CYCLES, SWITCH_GUARD);
    localparam logic [CNT_W-1:0]             LOCK_RELOAD = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [BUS_ADDR_DATA_LEN-1:0] CSR_ADDR    = BUS_ADDR_DATA_LEN'(PLLCSR_ADDR);
    localparam logic [BUS_ADDR_DATA_LEN-1:0] FRQ_ADDR    = BUS_ADDR_DATA_LEN'(PLLFRQ_ADDR);

    logic [7:1]       r_pllcsr;
    logic [7:0]       r_pllfrq;
    logic             r_frq_wr;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_pll_frq;

    logic             w_csr_sel;
    logic             w_frq_sel;
    logic             w_sw_idle;
    logic [7:0]       w_csr_rd;
    logic [1:0]       w_unused_bits;

    assign w_csr_sel = (addr_dat == CSR_ADDR);
    assign w_frq_sel = (addr_dat == FRQ_ADDR);

    // PLOCK is status only; PINDIV is consumed by the prescaler outside this block.
    assign w_unused_bits = {bus_dat_in[PLOCK_BIT], r_pllcsr[PINDIV_BIT]};

    // r_frq_wr delays the PLLFRQ write by one edge so the FSM acts on the stored value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pllcsr <= '0;
            r_pllfrq <= '0;
            r_frq_wr <= 1'b0;
        end else begin
            r_frq_wr <= wr_dat && w_frq_sel;
            if (wr_dat && w_csr_sel) begin
                r_pllcsr <= bus_dat_in[7:1];
            end
            if (wr_dat && w_frq_sel) begin
                r_pllfrq <= bus_dat_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_OFF;
            r_cnt     <= '0;
            r_pll_frq <= '0;
        end else if (!r_pllcsr[PLLE_BIT]) begin
            // Disable wins over everything, including a pending retune.
            r_state   <= ST_OFF;
            r_cnt     <= '0;
            r_pll_frq <= r_pllfrq;
        end else begin
            case (r_state)
                ST_OFF: begin
                    r_state   <= ST_LOCK;
                    r_cnt     <= LOCK_RELOAD;
                    r_pll_frq <= r_pllfrq;
                end
                ST_LOCK: begin
                    if (r_frq_wr) begin
                        r_pll_frq <= r_pllfrq;
                        r_cnt     <= LOCK_RELOAD;
                    end else if (r_cnt == '0) begin
                        r_state <= ST_LOCKED;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (r_frq_wr && (r_pllfrq != r_pll_frq)) begin
                        r_state <= ST_RETUNE;
                    end
                end
                ST_RETUNE: begin
                    // Divider may only change once the timer runs from the safe source.
                    if (w_sw_idle && (tim_sel == 2'b00)) begin
                        r_pll_frq <= r_pllfrq;
                        r_cnt     <= LOCK_RELOAD;
                        r_state   <= ST_LOCK;
                    end
                end
                default: begin
                    r_state <= ST_OFF;
                end
            endcase
        end
    end

    assign pll_run = (r_state != ST_OFF);
    assign plock   = (r_state == ST_LOCKED);
    assign pll_frq = r_pll_frq;

    always_comb begin
        w_csr_rd            = {r_pllcsr, 1'b0};
        w_csr_rd[PLOCK_BIT] = plock;
    end

    always_comb begin
        bus_dat_out = 8'h00;
        if (rd_dat && w_csr_sel) begin
            bus_dat_out = w_csr_rd;
        end else if (rd_dat && w_frq_sel) begin
            bus_dat_out = r_pllfrq;
        end
    end

    atmega_pll_clk_switch #(
        .SWITCH_GUARD (SWITCH_GUARD),
        .CNT_W        (CNT_W)
    ) u_clk_switch (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_plock    (plock),
        .i_frq_sel  (r_pll_frq[5:4]),
        .o_tim_sel  (tim_sel),
        .o_tim_gate (tim_gate),
        .o_sw_idle  (w_sw_idle)
    );

endmodule

// File: tb/tb_atmega_pll_ctrl.sv
// Bench for atmega_pll_ctrl: directed vector table, hand sequences for the
// retune/disable/reset corners, and random bus traffic against a timestamp model.
module tb_atmega_pll_ctrl;

    localparam int          L   = 8;
    localparam int          G   = 4;
    localparam logic [15:0] CSR = 16'h0049;
    localparam logic [15:0] FRQ = 16'h0052;

    logic        clk;
    logic        rst;
    logic [15:0] addr_dat;
    logic        wr_dat;
    logic        rd_dat;
    logic [7:0]  bus_dat_in;
    logic [7:0]  bus_dat_out;
    logic        pll_run;
    logic [7:0]  pll_frq;
    logic [1:0]  tim_sel;
    logic        tim_gate;
    logic        plock;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 0;

    atmega_pll_ctrl #(
        .BUS_ADDR_DATA_LEN (16),
        .PLLCSR_ADDR       ('h49),
        .PLLFRQ_ADDR       ('h52),
        .LOCK_CYCLES       (L),
        .SWITCH_GUARD      (G)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .addr_dat    (addr_dat),
        .wr_dat      (wr_dat),
        .rd_dat      (rd_dat),
        .bus_dat_in  (bus_dat_in),
        .bus_dat_out (bus_dat_out),
        .pll_run     (pll_run),
        .pll_frq     (pll_frq),
        .tim_sel     (tim_sel),
        .tim_gate    (tim_gate),
        .plock       (plock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: lock and switch progress tracked as absolute edge numbers.
    int         cyc;
    logic [7:0] m_csr, m_frq, m_pll_frq;
    logic       m_wr_prev, m_en, m_retune, m_plock;
    int         m_lock_at, m_sw_start;
    logic [1:0] m_sel;
    logic       m_gate, m_sw_idle;
    logic [7:0] o_frq, o_pll_frq;
    logic       o_plle, o_wr, o_plock, o_idle;
    logic [1:0] o_sel, tgt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc = 0; m_csr = 0; m_frq = 0; m_pll_frq = 0; m_wr_prev = 0;
            m_en = 0; m_retune = 0; m_plock = 0; m_lock_at = 0;
            m_sel = 0; m_gate = 1; m_sw_idle = 1; m_sw_start = 0;
        end else begin
            cyc++;
            o_plle = m_csr[1]; o_frq = m_frq; o_wr = m_wr_prev; o_plock = m_plock;
            o_pll_frq = m_pll_frq; o_sel = m_sel; o_idle = m_sw_idle;
            if (!o_plle) begin
                m_en = 0; m_retune = 0; m_pll_frq = o_frq;
            end else if (!m_en) begin
                m_en = 1; m_lock_at = cyc + L; m_pll_frq = o_frq;
            end else if (m_retune) begin
                if (o_idle && o_sel == 2'b00) begin
                    m_pll_frq = o_frq; m_retune = 0; m_lock_at = cyc + L;
                end
            end else if (o_plock) begin
                if (o_wr && o_frq != o_pll_frq) m_retune = 1;
            end else if (o_wr) begin
                m_pll_frq = o_frq; m_lock_at = cyc + L;
            end
            tgt = o_plock ? o_pll_frq[5:4] : 2'b00;
            if (o_idle) begin
                if (tgt != o_sel) begin
                    m_sw_idle = 0; m_sw_start = cyc; m_gate = 0;
                end
            end else if (cyc == m_sw_start + G) begin
                m_sel = tgt;
            end else if (cyc == m_sw_start + G + 1) begin
                m_gate = 1; m_sw_idle = 1;
            end
            m_wr_prev = wr_dat && addr_dat == FRQ;
            if (wr_dat && addr_dat == CSR) m_csr = bus_dat_in;
            if (wr_dat && addr_dat == FRQ) m_frq = bus_dat_in;
            m_plock = m_en && !m_retune && (cyc >= m_lock_at);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic run, input logic lk,
                           input logic [7:0] pf, input logic [1:0] sel, input logic gate);
        chk({tag, " pll_run"}, pll_run, run);
        chk({tag, " plock"}, plock, lk);
        chk({tag, " pll_frq"}, pll_frq, pf);
        chk({tag, " tim_sel"}, tim_sel, sel);
        chk({tag, " tim_gate"}, tim_gate, gate);
    endtask

    task automatic rd_chk(input string nm, input logic [15:0] a, input logic [7:0] exp);
        rd_dat = 1'b1; addr_dat = a;
        #1;
        chk(nm, bus_dat_out, exp);
        rd_dat = 1'b0; addr_dat = '0;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        addr_dat = a; bus_dat_in = d; wr_dat = 1'b1;
        @(negedge clk);
        wr_dat = 1'b0; addr_dat = '0; bus_dat_in = '0;
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (mon_en && rst) begin
            #2;
            if (rst) begin
                chk("mon pll_run", pll_run, m_en);
                chk("mon plock", plock, m_plock);
                chk("mon pll_frq", pll_frq, m_pll_frq);
                chk("mon tim_sel", tim_sel, m_sel);
                chk("mon tim_gate", tim_gate, m_gate);
                if (rd_dat && addr_dat == CSR)
                    chk("mon rd csr", bus_dat_out, {m_csr[7:1], m_plock});
                else if (rd_dat && addr_dat == FRQ)
                    chk("mon rd frq", bus_dat_out, m_frq);
                else
                    chk("mon rd idle", bus_dat_out, 8'h00);
            end
        end
    end

    typedef struct {
        bit          do_wr;
        logic [15:0] addr;
        logic [7:0]  data;
        int          waitn;
        logic [7:0]  exp_csr;
        logic [7:0]  exp_frq;
        logic [7:0]  exp_pf;
        logic        exp_run;
        logic        exp_plock;
        logic [1:0]  exp_sel;
        logic        exp_gate;
    } vec_t;

    vec_t vecs [0:10];

    initial begin
        vecs[0]  = '{1'b1, CSR, 8'h02, 1, 8'h02, 8'h00, 8'h00, 1'b1, 1'b0, 2'd0, 1'b1};
        vecs[1]  = '{1'b0, CSR, 8'h00, 7, 8'h02, 8'h00, 8'h00, 1'b1, 1'b0, 2'd0, 1'b1};
        vecs[2]  = '{1'b0, CSR, 8'h00, 1, 8'h03, 8'h00, 8'h00, 1'b1, 1'b1, 2'd0, 1'b1};
        vecs[3]  = '{1'b1, FRQ, 8'h14, 1, 8'h02, 8'h14, 8'h00, 1'b1, 1'b0, 2'd0, 1'b1};
        vecs[4]  = '{1'b0, CSR, 8'h00, 9, 8'h03, 8'h14, 8'h14, 1'b1, 1'b1, 2'd0, 1'b1};
        vecs[5]  = '{1'b0, CSR, 8'h00, 1, 8'h03, 8'h14, 8'h14, 1'b1, 1'b1, 2'd0, 1'b0};
        vecs[6]  = '{1'b0, CSR, 8'h00, 3, 8'h03, 8'h14, 8'h14, 1'b1, 1'b1, 2'd0, 1'b0};
        vecs[7]  = '{1'b0, CSR, 8'h00, 1, 8'h03, 8'h14, 8'h14, 1'b1, 1'b1, 2'd1, 1'b0};
        vecs[8]  = '{1'b0, CSR, 8'h00, 1, 8'h03, 8'h14, 8'h14, 1'b1, 1'b1, 2'd1, 1'b1};
        vecs[9]  = '{1'b1, FRQ, 8'h14, 1, 8'h03, 8'h14, 8'h14, 1'b1, 1'b1, 2'd1, 1'b1};
        vecs[10] = '{1'b0, CSR, 8'h00, 3, 8'h03, 8'h14, 8'h14, 1'b1, 1'b1, 2'd1, 1'b1};

        addr_dat = '0; wr_dat = 0; rd_dat = 0; bus_dat_in = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_out("reset", 1'b0, 1'b0, 8'h00, 2'd0, 1'b1);
        rd_chk("reset rd csr", CSR, 8'h00);
        rd_chk("reset rd frq", FRQ, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1;

        // Enable, lock, retune to 0x14, identical rewrite.
        for (int i = 0; i <= 10; i++) begin
            if (vecs[i].do_wr) bus_wr(vecs[i].addr, vecs[i].data);
            repeat (vecs[i].waitn) @(negedge clk);
            chk_out($sformatf("v%0d", i), vecs[i].exp_run, vecs[i].exp_plock,
                    vecs[i].exp_pf, vecs[i].exp_sel, vecs[i].exp_gate);
            rd_chk($sformatf("v%0d rd csr", i), CSR, vecs[i].exp_csr);
            rd_chk($sformatf("v%0d rd frq", i), FRQ, vecs[i].exp_frq);
        end

        // Retune while timer runs from source 01.
        bus_wr(FRQ, 8'h1A);
        repeat (1) @(negedge clk); chk_out("rt+1", 1'b1, 1'b0, 8'h14, 2'd1, 1'b1);
        repeat (5) @(negedge clk); chk_out("rt+6", 1'b1, 1'b0, 8'h14, 2'd0, 1'b0);
        repeat (2) @(negedge clk); chk_out("rt+8", 1'b1, 1'b0, 8'h1A, 2'd0, 1'b1);
        repeat (7) @(negedge clk); chk_out("rt+15", 1'b1, 1'b0, 8'h1A, 2'd0, 1'b1);
        repeat (1) @(negedge clk); chk_out("rt+16", 1'b1, 1'b1, 8'h1A, 2'd0, 1'b1);
        repeat (5) @(negedge clk); chk_out("rt+21", 1'b1, 1'b1, 8'h1A, 2'd1, 1'b0);
        repeat (1) @(negedge clk); chk_out("rt+22", 1'b1, 1'b1, 8'h1A, 2'd1, 1'b1);

        // Disable during the retune guard.
        bus_wr(FRQ, 8'h2A);
        repeat (1) @(negedge clk);
        bus_wr(CSR, 8'h00);
        repeat (1) @(negedge clk); chk_out("off+1", 1'b0, 1'b0, 8'h2A, 2'd1, 1'b0);
        repeat (2) @(negedge clk); chk_out("off+3", 1'b0, 1'b0, 8'h2A, 2'd1, 1'b0);
        repeat (1) @(negedge clk); chk_out("off+4", 1'b0, 1'b0, 8'h2A, 2'd0, 1'b0);
        repeat (1) @(negedge clk); chk_out("off+5", 1'b0, 1'b0, 8'h2A, 2'd0, 1'b1);
        rd_chk("off rd csr", CSR, 8'h00);
        rd_chk("off rd frq", FRQ, 8'h2A);

        // Re-enable, then pull reset in the middle of the guard.
        bus_wr(CSR, 8'h02);
        repeat (9) @(negedge clk); chk_out("en+9", 1'b1, 1'b1, 8'h2A, 2'd0, 1'b1);
        repeat (2) @(negedge clk); chk_out("en+11", 1'b1, 1'b1, 8'h2A, 2'd0, 1'b0);
        #3 rst = 1'b0;
        #1;
        chk_out("async rst", 1'b0, 1'b0, 8'h00, 2'd0, 1'b1);
        rd_chk("async rst rd csr", CSR, 8'h00);
        rd_chk("async rst rd frq", FRQ, 8'h00);
        @(negedge clk);
        rst = 1'b1;

        // Random bus traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            int r;
            logic [7:0] d;
            r = $urandom_range(0, 31);
            wr_dat = 0; rd_dat = 0; addr_dat = '0; bus_dat_in = '0;
            if (r == 0) begin
                d = 8'($urandom);
                d[1] = ($urandom_range(0, 9) != 0);
                wr_dat = 1; addr_dat = CSR; bus_dat_in = d;
            end else if (r <= 2) begin
                case ($urandom_range(0, 5))
                    0: d = 8'h00;
                    1: d = 8'h14;
                    2: d = 8'h1A;
                    3: d = 8'h2A;
                    4: d = 8'h3F;
                    default: d = 8'($urandom);
                endcase
                wr_dat = 1; addr_dat = FRQ; bus_dat_in = d;
            end else if (r <= 8) begin
                rd_dat = 1;
                case ($urandom_range(0, 2))
                    0: addr_dat = CSR;
                    1: addr_dat = FRQ;
                    default: addr_dat = 16'($urandom_range(0, 255));
                endcase
            end
            @(negedge clk);
        end
        wr_dat = 0; rd_dat = 0; addr_dat = '0; bus_dat_in = '0;
        @(negedge clk);
        mon_en = 0;

        rd_chk("rd other addr", 16'h0050, 8'h00);
        addr_dat = FRQ; rd_dat = 1'b0;
        #1;
        chk("rd strobe low", bus_dat_out, 8'h00);
        addr_dat = '0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
